// File: rtl/rr_onehot_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_onehot_arbiter_4
//
// Registered four-requester round-robin arbiter. The grant vector is always
// one-hot or all-zero, so it can drive a simple (non-priority) 4-to-2 encoder
// directly. A grant is held until the owner raises done, or until TIMEOUT
// cycles pass without done, whichever comes first. Every release is followed
// by one idle bubble cycle before the next grant.
//
// Parameters:
//   TIMEOUT  max cycles a grant is held without done (2..255)
//   CNT_W    hold counter width, 2**CNT_W > TIMEOUT
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request vector, req[i] = requester i wants the resource
//   done       owner releases the resource (only looked at while BUSY)
//   gnt[3:0]   registered one-hot grant, 4'b0000 when nobody owns it
//   gnt_valid  high while gnt is non-zero
//   timeout    one-cycle pulse when a grant is force-released
// -----------------------------------------------------------------------------
module rr_onehot_arbiter_4 #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_reg,   state_next;
    logic [1:0]         ptr_reg,     ptr_next;
    logic [1:0]         owner_reg,   owner_next;
    logic [CNT_W-1:0]   cnt_reg,     cnt_next;
    logic [3:0]         gnt_reg,     gnt_next;
    logic               timeout_reg, timeout_next;

    // Candidate index for each scan position: cand[k] = ptr + k (mod 4).
    logic [1:0] cand [4];
    logic [3:0] cand_hit;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_scan
            assign cand[gi]     = ptr_reg + 2'(gi);
            assign cand_hit[gi] = req[cand[gi]];
        end
    endgenerate

    // First hit in scan order ptr, ptr+1, ptr+2, ptr+3. Iterating from the
    // far end means the closest hit is the last assignment and wins.
    logic [1:0] winner_idx;
    logic       any_req;

    always_comb begin
        winner_idx = ptr_reg;
        for (int k = 3; k >= 0; k--) begin
            if (cand_hit[k]) begin
                winner_idx = cand[k];
            end
        end
    end

    assign any_req = |req;

    // Release happens on done, or on the last allowed hold cycle.
    logic hold_expired;
    logic do_release;

    assign hold_expired = (cnt_reg == CNT_W'(TIMEOUT - 1));
    assign do_release   = (state_reg == BUSY) && (done || hold_expired);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            ptr_reg     <= 2'd0;
            owner_reg   <= 2'd0;
            cnt_reg     <= '0;
            gnt_reg     <= 4'b0000;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            owner_reg   <= owner_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            timeout_reg <= timeout_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (do_release) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath / registered-output next values
    // ------------------------------------------------------------------
    always_comb begin
        ptr_next     = ptr_reg;
        owner_next   = owner_reg;
        cnt_next     = cnt_reg;
        gnt_next     = gnt_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    owner_next = winner_idx;
                    // Decoding from an index keeps the grant one-hot by
                    // construction.
                    gnt_next   = 4'b0001 << winner_idx;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (do_release) begin
                    gnt_next     = 4'b0000;
                    cnt_next     = '0;
                    ptr_next     = owner_reg + 2'd1;
                    // A done on the expiry cycle is a normal release.
                    timeout_next = !done;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                gnt_next = 4'b0000;
                cnt_next = '0;
            end
        endcase
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = |gnt_reg;
    assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_onehot_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_rr_onehot_arbiter_4
//
// Directed bench for rr_onehot_arbiter_4 built with TIMEOUT=4. Inputs change
// 2 time units after a rising edge; outputs are checked at that same point,
// i.e. they show the result of the edge just taken. A separate process
// checks the one-hot / gnt_valid invariant on every falling edge.
// -----------------------------------------------------------------------------
module tb_rr_onehot_arbiter_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    rr_onehot_arbiter_4 #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Grant/valid/timeout together after one step.
    task automatic chk_out(input string tag, input logic [3:0] exp_gnt, input logic exp_to);
        chk({tag, ".gnt"}, gnt, exp_gnt);
        chk({tag, ".valid"}, {3'b000, gnt_valid}, {3'b000, (exp_gnt != 4'b0000)});
        chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, exp_to});
        $display("step %-10s req=%b done=%b gnt=%b valid=%b timeout=%b",
                 tag, req, done, gnt, gnt_valid, timeout);
    endtask

    // Invariant: gnt in {0000,0001,0010,0100,1000} and gnt_valid == |gnt.
    always @(negedge clk) begin
        logic legal;
        legal = (gnt === 4'b0000) || (gnt === 4'b0001) || (gnt === 4'b0010) ||
                (gnt === 4'b0100) || (gnt === 4'b1000);
        checks++;
        assert (legal && (gnt_valid === (gnt != 4'b0000)))
        else begin
            errors++;
            $error("FAIL invariant observed gnt=%b valid=%b expected onehot and valid=|gnt",
                   gnt, gnt_valid);
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #1;
        chk_out("reset", 4'b0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("idle", 4'b0000, 1'b0);

        // Fairness: all requesting, done pulsed every BUSY cycle.
        req = 4'b1111;
        tick(); chk_out("rr_g0", 4'b0001, 1'b0);
        done = 1'b1;
        tick(); chk_out("rr_r0", 4'b0000, 1'b0);
        done = 1'b0;
        tick(); chk_out("rr_g1", 4'b0010, 1'b0);
        done = 1'b1;
        tick(); chk_out("rr_r1", 4'b0000, 1'b0);
        done = 1'b0;
        tick(); chk_out("rr_g2", 4'b0100, 1'b0);
        done = 1'b1;
        tick(); chk_out("rr_r2", 4'b0000, 1'b0);
        done = 1'b0;
        tick(); chk_out("rr_g3", 4'b1000, 1'b0);
        done = 1'b1;
        tick(); chk_out("rr_r3", 4'b0000, 1'b0);
        done = 1'b0;
        tick(); chk_out("rr_g0b", 4'b0001, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        tick(); chk_out("rr_rel", 4'b0000, 1'b0);      // ptr -> 1
        done = 1'b0;

        // Single requester 2 from ptr=1.
        req = 4'b0100;
        tick(); chk_out("single_g", 4'b0100, 1'b0);
        done = 1'b1;
        tick(); chk_out("single_r", 4'b0000, 1'b0);    // ptr -> 3
        done = 1'b0;
        req  = 4'b0000;
        tick(); chk_out("no_req", 4'b0000, 1'b0);

        // Wrap: ptr=3, req=0011 -> 0 first, then 1.
        req = 4'b0011;
        tick(); chk_out("wrap_g0", 4'b0001, 1'b0);
        done = 1'b1;
        tick(); chk_out("wrap_r0", 4'b0000, 1'b0);     // ptr -> 1
        done = 1'b0;
        tick(); chk_out("wrap_g1", 4'b0010, 1'b0);     // BUSY, count=0

        // Hold: requests change, grant stays; done on the expiry cycle.
        req = 4'b0000;
        tick(); chk_out("hold_a", 4'b0010, 1'b0);      // count=1
        req = 4'b1100;
        tick(); chk_out("hold_b", 4'b0010, 1'b0);      // count=2
        tick(); chk_out("hold_c", 4'b0010, 1'b0);      // count=3
        done = 1'b1;
        tick(); chk_out("done_exp", 4'b0000, 1'b0);    // ptr -> 2
        done = 1'b0;
        tick(); chk_out("after_exp", 4'b0100, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        tick(); chk_out("rel2", 4'b0000, 1'b0);        // ptr -> 3
        done = 1'b0;

        // Timeout: requester 3 holds 4 cycles, then forced release.
        req = 4'b1000;
        tick(); chk_out("to_1", 4'b1000, 1'b0);
        tick(); chk_out("to_2", 4'b1000, 1'b0);
        tick(); chk_out("to_3", 4'b1000, 1'b0);
        tick(); chk_out("to_4", 4'b1000, 1'b0);
        req = 4'b0001;
        tick(); chk_out("to_rel", 4'b0000, 1'b1);      // ptr -> 0
        tick(); chk_out("to_next", 4'b0001, 1'b0);
        done = 1'b1;
        req  = 4'b0000;
        tick(); chk_out("to_done", 4'b0000, 1'b0);     // ptr -> 1

        // done held through the bubble: ignored in IDLE, releases in BUSY.
        req = 4'b0010;
        tick(); chk_out("dh_g", 4'b0010, 1'b0);
        tick(); chk_out("dh_r", 4'b0000, 1'b0);        // ptr -> 2
        done = 1'b0;

        // Asynchronous reset in the middle of a grant.
        req = 4'b0100;
        tick(); chk_out("rst_busy", 4'b0100, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 4'b0000, 1'b0);
        req = 4'b1111;
        tick(); chk_out("rst_hold", 4'b0000, 1'b0);
        rst_n = 1'b1;
        tick(); chk_out("rst_ptr0", 4'b0001, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
